// File: rtl/rev_wire_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rev_wire_stage : wire-state stage for a 2-control / 4-target CXOR gate.   |
// | Optional VERIFY self-check enabled by macro REV_SELFCHECK_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rev_wire_stage #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] gate_in,
  input  logic [WIDTH-1:0] gate_res,
  output logic [WIDTH-1:0] wire_q,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic             err_check
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_COMMIT = 2'd2,
    S_VERIFY = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t state_q;
  logic   dir_q;
  logic   range_bad;

  // After COMMIT the wire register already holds the new state, so VERIFY needs no mux.
  assign gate_in   = wire_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && !load_valid;
  assign range_bad = cmd_dir ? (step_cnt == '0) : (step_cnt == C_CNT_MAX);

`ifdef REV_SELFCHECK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             err_check_q;

  assign err_check = err_check_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      wire_q      <= '0;
      step_cnt    <= '0;
      done        <= 1'b0;
      err_range   <= 1'b0;
      shadow_q    <= '0;
      err_check_q <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_range <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            wire_q   <= load_data;
            step_cnt <= '0;
          end else if (cmd_valid) begin
            if (range_bad) begin
              err_range <= 1'b1;
            end else begin
              dir_q   <= cmd_dir;
              state_q <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          shadow_q <= wire_q;
          wire_q   <= gate_res;
          step_cnt <= dir_q ? step_cnt - 1'b1 : step_cnt + 1'b1;
          state_q  <= S_COMMIT;
        end
        S_COMMIT: begin
          done    <= 1'b1;
          state_q <= S_VERIFY;
        end
        S_VERIFY: begin
          // Self-inverse gate: re-applying it to the new state must give back the old one.
          if (gate_res != shadow_q) err_check_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign err_check = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      wire_q    <= '0;
      step_cnt  <= '0;
      done      <= 1'b0;
      err_range <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_range <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            wire_q   <= load_data;
            step_cnt <= '0;
          end else if (cmd_valid) begin
            if (range_bad) begin
              err_range <= 1'b1;
            end else begin
              dir_q   <= cmd_dir;
              state_q <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          wire_q   <= gate_res;
          step_cnt <= dir_q ? step_cnt - 1'b1 : step_cnt + 1'b1;
          done     <= 1'b1;
          state_q  <= S_COMMIT;
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire
